pdm_mic_ctrl: RTL and testbench
===============================

# pdm_mic_ctrl

Sequencer for the PDM microphone / PWM amplifier audio path. Generates the mic bit clock from the 100 MHz system clock, holds the amplifier in shutdown through mic power-up settling, then samples PDM data, forwards it to the amplifier, and reports a per-window ones-density count. Stop requests drain cleanly at a window boundary so the amplifier is never cut mid-window.

## Interface
- DIV_HALF, 16: system clocks per sclk half-period (sclk = clk / (2*DIV_HALF) = 3.125 MHz); legal range ≥ 2.
- SETTLE, 1024: sclk periods discarded after wake before the amplifier is enabled.
- WINDOW, 64: samples per density window; legal range ≥ 2.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin capture; sampled in IDLE only.
- stop  in  1  one-cycle request to end capture.
- lr_sel  in  1  mic L/R select; latched on start.
- sdata  in  1  PDM data from mic.
- sclk  out  1  mic bit clock.
- ncs  out  1  mic LRSel, the latched lr_sel.
- ampSD  out  1  amplifier enable, active high.
- anout  out  1  PWM audio to amplifier.
- busy  out  1  high in any state except IDLE.
- pcm_valid  out  1  one-cycle pulse when a density window completes.
- pcm_count  out  $clog2(WINDOW+1)  ones in the last window; holds between pulses.

## Operation
- States: IDLE, WAKE, RUN, DRAIN.
- IDLE: divider held at 0, sclk=0, ampSD=0, anout=0. start -> WAKE. If start and stop are high in the same cycle, stop wins and the block stays in IDLE.
- WAKE: sclk runs. Counts sclk rising edges. After SETTLE rising edges -> RUN. stop -> IDLE on the next cycle.
- RUN: ampSD=1. Each sample strobe registers sdata into anout and into the window accumulator. After WINDOW strobes: pcm_valid pulses, pcm_count loads, accumulator and sample counter clear. stop -> DRAIN.
- DRAIN: continues as RUN until the current window completes, including its pcm_valid pulse, then -> IDLE. A stop that arrives on the final strobe of a window still completes that window and exits. Further stops are ignored.
- start outside IDLE is ignored.
- Divider: counts 0..DIV_HALF-1, toggles sclk when it wraps.
- Sample strobe: divider == DIV_HALF-1 while sclk==1 (last clk cycle before the sclk falling edge).
- Accumulator saturation is impossible by sizing ($clog2(WINDOW+1) bits).
- Entering IDLE: ampSD and anout drop to 0 on the same cycle. pcm_count retains its last value.

## Timing
- Reset values: sclk=0, ncs=0, ampSD=0, anout=0, busy=0, pcm_valid=0, pcm_count=0, state=IDLE. Reset mid-operation returns all outputs to these values immediately (asynchronous).
- start at cycle t: busy=1 at t+1. First sclk rise at t+DIV_HALF.
- ampSD rises on the cycle RUN is entered, one cycle after the SETTLE-th sclk rising edge.
- anout updates one clk cycle after its strobe. pcm_valid asserts the cycle after the WINDOW-th strobe, aligned with the new pcm_count.
- sclk duty is exactly 50%. No glitches, since sclk is a registered output.

## Structure
- Shared package pdm_pkg holds the state enum (IDLE/WAKE/RUN/DRAIN) and default constants (DIV_HALF, SETTLE, WINDOW).
- Sub-module pdm_clkgen contains the divider, the sclk register, and the rise/strobe pulse outputs, with enable and clear inputs.
- The FSM, settle counter, and window accumulator are in the top module.

## Test plan
All scenarios use DIV_HALF=2, SETTLE=4, WINDOW=8.
- Reset: pulse rst_n low mid-RUN -> all outputs at reset values within the same cycle; busy=0.
- Wake: start at t -> sclk period 4 clks. ampSD=1 one cycle after the 4th sclk rise. anout stays 0 before that.
- Density: sdata held 1 in RUN -> pcm_count=8 on each pcm_valid. Alternating 1/0 per strobe -> pcm_count=4. anout follows sdata with a 1-clk lag after each strobe.
- Drain: stop after the 3rd strobe of a window -> 5 more strobes, pcm_valid with the window count, then IDLE; ampSD=0 and sclk=0.
- Abort in WAKE: stop after the 2nd sclk rise -> IDLE next cycle; ampSD never asserts; pcm_valid never pulses.
- Corner cases:
  - start+stop together in IDLE -> remain IDLE.
  - start while in RUN -> ignored.
  - lr_sel changed while busy -> ncs keeps its latched value.

Source files
------------

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared definitions for the PDM microphone / PWM amplifier path.
//   - pdm_state_e  : sequencer states (IDLE, WAKE, RUN, DRAIN)
//   - *_DEF        : default divider, settle and window sizes
package pdm_pkg;

  // 100 MHz / (2*16) = 3.125 MHz mic bit clock
  localparam int DIV_HALF_DEF = 16;
  // sclk periods discarded while the mic powers up
  localparam int SETTLE_DEF   = 1024;
  // samples per ones-density window
  localparam int WINDOW_DEF   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAKE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } pdm_state_e;

endpackage

// File: rtl/pdm_clkgen.sv
// pdm_clkgen: mic bit-clock generator.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   i_en       : advance the divider
//   i_clr      : hold divider and sclk at 0 (wins over i_en)
//   o_sclk     : registered 50% duty bit clock
//   o_rise     : high for the first clk cycle of every sclk high phase
//   o_strobe   : high on the last clk cycle before the sclk falling edge
module pdm_clkgen
  import pdm_pkg::*;
#(
  parameter int DIV_HALF = DIV_HALF_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_sclk,
  output logic o_rise,
  output logic o_strobe
);

  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);

  logic [DW-1:0] r_div;
  logic          r_sclk;
  logic          r_rise;
  logic          w_wrap;

  assign w_wrap = (r_div == DIV_LAST);

  // Divider, sclk toggle on wrap, and registered rising-edge marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
      r_rise <= 1'b0;
    end else if (i_clr) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
      r_rise <= 1'b0;
    end else if (i_en) begin
      // sclk goes high on this edge exactly when we wrap from the low phase
      r_rise <= w_wrap & ~r_sclk;
      if (w_wrap) begin
        r_div  <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_div  <= r_div + DW'(1);
      end
    end else begin
      r_rise <= 1'b0;
    end
  end

  assign o_sclk   = r_sclk;
  assign o_rise   = r_rise;
  assign o_strobe = r_sclk & w_wrap;

endmodule

// File: rtl/pdm_mic_ctrl.sv
// pdm_mic_ctrl: PDM mic / PWM amp sequencer.
// Generates sclk, keeps the amp in shutdown during mic settling, then forwards
// sampled PDM bits to the amp and reports ones-density per window. Stop
// requests during capture drain at the next window boundary.
// Ports:
//   clk, rst_n       : 100 MHz system clock, async active-low reset
//   start, stop      : one-cycle requests (stop wins when both in IDLE)
//   lr_sel           : mic L/R select, latched on accepted start -> ncs
//   sdata            : PDM data from mic
//   sclk             : mic bit clock
//   ampSD, anout     : amplifier enable and PWM audio
//   busy             : any state but IDLE
//   pcm_valid        : one-cycle pulse per completed window
//   pcm_count        : ones counted in the last completed window
module pdm_mic_ctrl
  import pdm_pkg::*;
#(
  parameter int DIV_HALF = DIV_HALF_DEF,
  parameter int SETTLE   = SETTLE_DEF,
  parameter int WINDOW   = WINDOW_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         lr_sel,
  input  logic                         sdata,
  output logic                         sclk,
  output logic                         ncs,
  output logic                         ampSD,
  output logic                         anout,
  output logic                         busy,
  output logic                         pcm_valid,
  output logic [$clog2(WINDOW+1)-1:0]  pcm_count
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int NW = $clog2(WINDOW);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [NW-1:0] SMP_LAST    = NW'(WINDOW - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  pdm_state_e    r_state;
  pdm_state_e    w_state_nxt;
  logic          w_start_acc;
  logic          w_active;
  logic          w_take;
  logic          w_rise;
  logic          w_strobe;
  logic          w_clk_clr;
  logic          w_clk_en;
  logic [CW-1:0] w_sum;

  logic          r_ncs;
  logic          r_amp;
  logic          r_anout;
  logic          r_busy;
  logic          r_pcm_valid;
  logic [CW-1:0] r_pcm_count;
  logic [CW-1:0] r_acc;
  logic [NW-1:0] r_scnt;
  logic [SW-1:0] r_settle;

  assign w_start_acc = (r_state == ST_IDLE) & start & ~stop;
  assign w_active    = (r_state == ST_RUN) | (r_state == ST_DRAIN);
  assign w_take      = w_active & w_strobe;
  assign w_sum       = r_acc + CW'(sdata);

  // Divider runs from the cycle start is accepted so the first sclk rise
  // lands DIV_HALF cycles later; it is cleared on the way into IDLE.
  assign w_clk_clr = (w_state_nxt == ST_IDLE);
  assign w_clk_en  = (r_state != ST_IDLE) | w_start_acc;

  pdm_clkgen #(
    .DIV_HALF (DIV_HALF)
  ) u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_clk_en),
    .i_clr    (w_clk_clr),
    .o_sclk   (sclk),
    .o_rise   (w_rise),
    .o_strobe (w_strobe)
  );

  // Next-state logic for the capture sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_acc) w_state_nxt = ST_WAKE;
        else             w_state_nxt = ST_IDLE;
      end
      ST_WAKE: begin
        if (stop)                                   w_state_nxt = ST_IDLE;
        else if (w_rise && (r_settle == SETTLE_LAST)) w_state_nxt = ST_RUN;
        else                                        w_state_nxt = ST_WAKE;
      end
      ST_RUN: begin
        if (stop) w_state_nxt = ST_DRAIN;
        else      w_state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        // leave once the window in flight has published its count
        if (r_pcm_valid) w_state_nxt = ST_IDLE;
        else             w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered status / amplifier outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_amp   <= 1'b0;
      r_anout <= 1'b0;
      r_ncs   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_amp   <= (w_state_nxt == ST_RUN) | (w_state_nxt == ST_DRAIN);
      if (w_state_nxt == ST_IDLE) r_anout <= 1'b0;
      else if (w_take)            r_anout <= sdata;
      if (w_start_acc) r_ncs <= lr_sel;
    end
  end

  // Settle counter: sclk rising edges seen while in WAKE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
    end else if (r_state != ST_WAKE) begin
      r_settle <= '0;
    end else if (w_rise) begin
      r_settle <= r_settle + SW'(1);
    end
  end

  // Window accumulator, sample counter and density report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_scnt      <= '0;
      r_pcm_count <= '0;
      r_pcm_valid <= 1'b0;
    end else begin
      r_pcm_valid <= 1'b0;
      if (!w_active) begin
        r_acc  <= '0;
        r_scnt <= '0;
      end else if (w_take) begin
        if (r_scnt == SMP_LAST) begin
          r_pcm_count <= w_sum;
          r_pcm_valid <= 1'b1;
          r_acc       <= '0;
          r_scnt      <= '0;
        end else begin
          r_acc  <= w_sum;
          r_scnt <= r_scnt + NW'(1);
        end
      end
    end
  end

  assign ncs       = r_ncs;
  assign ampSD     = r_amp;
  assign anout     = r_anout;
  assign busy      = r_busy;
  assign pcm_valid = r_pcm_valid;
  assign pcm_count = r_pcm_count;

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// tb_pdm_mic_ctrl: self-checking bench for pdm_mic_ctrl (DIV_HALF=2,
// SETTLE=4, WINDOW=8). A reference model derives every output from the start
// time with plain arithmetic (sclk phase, RUN entry time, strobe instants)
// and a queue of sampled bits per window.
module tb_pdm_mic_ctrl;

  localparam int DH = 2;
  localparam int ST = 4;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic lr_sel = 1'b0;
  logic sdata = 1'b0;
  logic sclk, ncs, ampSD, anout, busy, pcm_valid;
  logic [CW-1:0] pcm_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pdm_mic_ctrl #(.DIV_HALF(DH), .SETTLE(ST), .WINDOW(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .lr_sel(lr_sel),
    .sdata(sdata), .sclk(sclk), .ncs(ncs), .ampSD(ampSD), .anout(anout),
    .busy(busy), .pcm_valid(pcm_valid), .pcm_count(pcm_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc = 0;
  int m_on = 0, m_t0 = 0, m_run_at = 0, m_drain = 0;
  int q[$];
  bit m_strobe_ev = 1'b0;
  logic e_sclk = 1'b0, e_amp = 1'b0, e_anout = 1'b0, e_busy = 1'b0;
  logic e_pv = 1'b0, e_ncs = 1'b0;
  logic [CW-1:0] e_cnt = '0;

  always @(posedge clk or negedge rst_n) begin
    int c, ph, sum;
    bit strobe, running, leave, nxt_pv;
    if (!rst_n) begin
      cyc = 0; m_on = 0; m_drain = 0; q.delete(); m_strobe_ev = 1'b0;
      e_sclk = 1'b0; e_amp = 1'b0; e_anout = 1'b0; e_busy = 1'b0;
      e_pv = 1'b0; e_ncs = 1'b0; e_cnt = '0;
    end else begin
      c = cyc; strobe = 1'b0; running = 1'b0; leave = 1'b0; nxt_pv = 1'b0;
      if (m_on == 0) begin
        if (start && !stop) begin
          m_on = 1; m_t0 = c; m_drain = 0; q.delete(); e_ncs = lr_sel;
          // SETTLE-th rise at t0 + DH + (SETTLE-1)*2*DH, RUN one cycle later
          m_run_at = c + DH + (ST - 1) * 2 * DH + 1;
        end
      end else begin
        ph = c - m_t0;
        strobe = (ph % (2 * DH)) == (2 * DH - 1);
        running = (c >= m_run_at);
        if (running) begin
          if (m_drain != 0 && e_pv) begin
            leave = 1'b1;
          end else begin
            if (strobe) begin
              q.push_back(int'(sdata));
              e_anout = sdata;
              if (q.size() == W) begin
                sum = 0;
                foreach (q[i]) sum += q[i];
                e_cnt = CW'(sum);
                nxt_pv = 1'b1;
                q.delete();
              end
            end
            if (stop) m_drain = 1;
          end
        end else if (stop) begin
          leave = 1'b1;
        end
      end
      e_pv = nxt_pv;
      if (leave) m_on = 0;
      if (m_on != 0) begin
        ph = c + 1 - m_t0;
        e_sclk = ((ph / DH) % 2) == 1;
        e_amp  = (c + 1) >= m_run_at;
        e_busy = 1'b1;
      end else begin
        e_sclk = 1'b0; e_amp = 1'b0; e_anout = 1'b0; e_busy = 1'b0;
      end
      m_strobe_ev = strobe & running;
      cyc = c + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("sclk", sclk, e_sclk);
    chk("ampSD", ampSD, e_amp);
    chk("anout", anout, e_anout);
    chk("busy", busy, e_busy);
    chk("pcm_valid", pcm_valid, e_pv);
    chk("pcm_count", pcm_count, e_cnt);
    chk("ncs", ncs, e_ncs);
  end

  // Event monitor for the directed scenarios
  int pv_n = 0, amp_n = 0;
  logic [CW-1:0] last_cnt = '0;
  always @(negedge clk) begin
    if (pcm_valid === 1'b1) begin pv_n++; last_cnt = pcm_count; end
    if (ampSD === 1'b1) amp_n++;
  end

  // sdata source: 0 = all ones, 1 = alternate per strobe, 2 = random
  int sd_mode = 2;
  initial begin
    forever begin
      @(posedge clk); #1;
      case (sd_mode)
        0: sdata = 1'b1;
        1: if (m_strobe_ev) sdata = ~sdata;
        default: sdata = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pv(input int k, input int budget);
    int target, n;
    target = pv_n + k; n = 0;
    while (pv_n < target && n < budget) begin @(negedge clk); #1; n++; end
    chk("pv_timeout", (pv_n >= target), 1);
  endtask

  task automatic wait_q(input int k, input int budget);
    int n;
    n = 0;
    while (q.size() != k && n < budget) begin @(negedge clk); #1; n++; end
    chk("q_timeout", (q.size() == k), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); #1; n++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  initial begin
    int n, pv0, a0;
    // reset values
    tick(3);
    chk("rst_sclk", sclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_amp", ampSD, 0);
    chk("rst_cnt", pcm_count, 0);
    rst_n = 1'b1;
    tick(2);

    // start+stop together: stop wins
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    tick(4);
    chk("ss_busy", busy, 0);
    chk("ss_sclk", sclk, 0);

    // wake latency and lr_sel latch
    sd_mode = 0; lr_sel = 1'b1;
    pulse_start();
    lr_sel = 1'b0;
    n = 0;
    while (ampSD !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("amp_latency", n, 15);
    chk("ncs_latched", ncs, 1);

    // start during RUN is ignored; all-ones density
    pulse_start();
    wait_pv(2, 200);
    chk("ones_count", last_cnt, 8);

    // alternating density
    sd_mode = 1;
    wait_pv(2, 200);
    chk("alt_count", last_cnt, 4);
    wait_pv(1, 100);
    chk("alt_count2", last_cnt, 4);

    // drain: stop after the 3rd strobe of a window
    sd_mode = 2;
    wait_pv(1, 100);
    wait_q(3, 100);
    pv0 = pv_n;
    pulse_stop();
    wait_idle(200);
    chk("drain_pv", pv_n - pv0, 1);
    chk("drain_amp", ampSD, 0);
    chk("drain_sclk", sclk, 0);

    // stop on the final strobe of a window
    pulse_start();
    wait_pv(1, 200);
    wait_q(7, 100);
    pv0 = pv_n;
    tick(3);
    pulse_stop();
    wait_idle(20);
    chk("final_strobe_pv", pv_n - pv0, 1);

    // abort in WAKE after the 2nd sclk rise
    a0 = amp_n; pv0 = pv_n;
    pulse_start();
    tick(6);
    pulse_stop();
    wait_idle(10);
    tick(20);
    chk("abort_amp", amp_n - a0, 0);
    chk("abort_pv", pv_n - pv0, 0);

    // asynchronous reset mid-RUN
    lr_sel = 1'b1;
    pulse_start();
    wait_pv(1, 200);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_sclk", sclk, 0);
    chk("arst_ncs", ncs, 0);
    chk("arst_amp", ampSD, 0);
    chk("arst_anout", anout, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pv", pcm_valid, 0);
    chk("arst_cnt", pcm_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // randomized sessions with stray start/stop pulses
    for (int it = 0; it < 10; it++) begin
      lr_sel = 1'($urandom_range(0, 1));
      start = 1'b1;
      stop = ($urandom_range(0, 7) == 0);
      tick(1);
      start = 1'b0; stop = 1'b0;
      lr_sel = 1'($urandom_range(0, 1));
      repeat ($urandom_range(5, 150)) begin
        start = ($urandom_range(0, 15) == 0);
        tick(1);
      end
      start = 1'b0;
      pulse_stop();
      if ($urandom_range(0, 1) == 1) pulse_stop();
      wait_idle(200);
      tick($urandom_range(1, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
